// File: rtl/alien_pkg.sv
// ---------------------------------------------------------------------------
// alien_pkg
// Shared types and helpers for the alien hit resolver.
//   coord_t      : 16-bit unsigned screen coordinate
//   hit_state_e  : resolver state encoding
//   DEFAULT_ALIEN_WIDTH / DEFAULT_ALIEN_HEIGHT : sprite size defaults
//   grid_index() : flat alive-matrix bit index for (row, col)
// ---------------------------------------------------------------------------
package alien_pkg;

   typedef logic [15:0] coord_t;

   typedef enum logic [2:0] {
      ARMED      = 3'd0,
      DIV_X      = 3'd1,
      DIV_Y      = 3'd2,
      CHECK      = 3'd3,
      KILL       = 3'd4,
      WAIT_FRAME = 3'd5
   } hit_state_e;

   localparam int DEFAULT_ALIEN_WIDTH  = 32;
   localparam int DEFAULT_ALIEN_HEIGHT = 16;

   // Flat bit index into the packed alive matrix: row*num_columns + col.
   function automatic logic [15:0] grid_index(input logic [7:0] row,
                                              input logic [7:0] col,
                                              input logic [7:0] num_columns);
      return ({8'd0, row} * {8'd0, num_columns}) + {8'd0, col};
   endfunction

endpackage

// File: rtl/alien_grid_divider.sv
// ---------------------------------------------------------------------------
// alien_grid_divider
// Repeated-subtraction divider mapping a pixel offset onto a grid cell.
// One subtraction per cycle; stops once the remainder drops below PITCH or
// the quotient reaches LIMIT (so the quotient never exceeds LIMIT).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, loads dividend and clears the quotient
//   dividend   : offset to divide (sampled on start)
//   quotient   : number of whole pitches removed (held after done)
//   remainder  : offset left over (held after done)
//   done       : high for the single cycle in which the division finishes
// ---------------------------------------------------------------------------
module alien_grid_divider
   import alien_pkg::*;
#(
   parameter int LIMIT = 4,
   parameter int PITCH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  coord_t     dividend,
   output logic [7:0] quotient,
   output coord_t     remainder,
   output logic       done
);

   localparam logic [7:0] LIMIT_Q = 8'(LIMIT);
   localparam coord_t     PITCH_C = coord_t'(PITCH);

   logic       run_r;
   logic [7:0] quot_r;
   coord_t     rem_r;
   logic       step_s;

   // Decide whether another subtraction is due this cycle.
   always_comb begin
      step_s = 1'b0;
      if (run_r && (rem_r >= PITCH_C) && (quot_r < LIMIT_Q)) begin
         step_s = 1'b1;
      end else begin
         step_s = 1'b0;
      end
   end

   // Done is combinational so the caller can chain the next stage with no
   // extra cycle of latency.
   assign done      = run_r && !step_s;
   assign quotient  = quot_r;
   assign remainder = rem_r;

   // Divider datapath: load on start, subtract while allowed, then idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_r  <= 1'b0;
         quot_r <= 8'd0;
         rem_r  <= 16'd0;
      end else if (start) begin
         run_r  <= 1'b1;
         quot_r <= 8'd0;
         rem_r  <= dividend;
      end else if (step_s) begin
         rem_r  <= rem_r - PITCH_C;
         quot_r <= quot_r + 8'd1;
      end else begin
         run_r  <= 1'b0;
      end
   end

endmodule

// File: rtl/alien_hit_resolver.sv
// ---------------------------------------------------------------------------
// alien_hit_resolver
// Detects the first bullet/alien pixel overlap of a frame, maps the scan
// position to a formation grid cell, checks the cell is a live alien and
// issues a valid/ready kill request. At most one kill per frame.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   scan_x, scan_y             : current VGA scan position
//   frame_start                : one-cycle pulse at the start of a frame
//   alien_pixel, bullet_pixel  : pixels at the scan position
//   formation_x, formation_y   : formation origin
//   alive_matrix               : packed alive bits, index row*NUM_COLUMNS+col
//   kill_valid/kill_ready      : kill request handshake
//   kill_row, kill_col         : grid cell to kill, stable while kill_valid
//   bullet_hit                 : one-cycle pulse on a confirmed hit
//   hit_count                  : saturating count of accepted kills
//   busy                       : resolver is mid-resolution or killing
// ---------------------------------------------------------------------------
module alien_hit_resolver
   import alien_pkg::*;
#(
   parameter int NUM_ROWS        = 2,
   parameter int NUM_COLUMNS     = 4,
   parameter int ALIEN_SPACING_X = 64,
   parameter int ALIEN_SPACING_Y = 32,
   parameter int ALIEN_WIDTH     = DEFAULT_ALIEN_WIDTH,
   parameter int ALIEN_HEIGHT    = DEFAULT_ALIEN_HEIGHT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [15:0]                     scan_x,
   input  logic [15:0]                     scan_y,
   input  logic                            frame_start,
   input  logic                            alien_pixel,
   input  logic                            bullet_pixel,
   input  logic [15:0]                     formation_x,
   input  logic [15:0]                     formation_y,
   input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
   output logic                            kill_valid,
   input  logic                            kill_ready,
   output logic [7:0]                      kill_row,
   output logic [7:0]                      kill_col,
   output logic                            bullet_hit,
   output logic [15:0]                     hit_count,
   output logic                            busy
);

   localparam int         CELLS = NUM_ROWS * NUM_COLUMNS;
   localparam int         IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [7:0] NR_Q  = 8'(NUM_ROWS);
   localparam logic [7:0] NC_Q  = 8'(NUM_COLUMNS);
   localparam coord_t     W_C   = coord_t'(ALIEN_WIDTH);
   localparam coord_t     H_C   = coord_t'(ALIEN_HEIGHT);

   hit_state_e state_r, state_s;
   logic       pending_r, pending_s;
   logic       miss_r;
   coord_t     dy_r;

   logic       overlap_s, miss_s, pend_any_s;
   coord_t     dx_s, dy_s;
   logic       start_x_s, start_y_s;
   logic       x_done_s, y_done_s;
   logic [7:0] col_s, row_s;
   coord_t     rem_x_s, rem_y_s;
   logic       hit_valid_s;
   logic [IDX_W-1:0] idx_s;

   logic        kill_valid_r, bullet_hit_r, busy_r;
   logic [7:0]  kill_row_r, kill_col_r;
   logic [15:0] hit_count_r;

   assign overlap_s  = alien_pixel && bullet_pixel;
   assign miss_s     = (scan_x < formation_x) || (scan_y < formation_y);
   // A miss feeds zero offsets so the subtraction can never wrap.
   assign dx_s       = miss_s ? 16'd0 : (scan_x - formation_x);
   assign dy_s       = miss_s ? 16'd0 : (scan_y - formation_y);
   assign start_x_s  = (state_r == ARMED) && overlap_s;
   assign start_y_s  = (state_r == DIV_X) && x_done_s;
   assign pend_any_s = pending_r || frame_start;

   alien_grid_divider #(.LIMIT(NUM_COLUMNS), .PITCH(ALIEN_SPACING_X)) u_div_x (
      .clk       (clk),
      .rst       (rst),
      .start     (start_x_s),
      .dividend  (dx_s),
      .quotient  (col_s),
      .remainder (rem_x_s),
      .done      (x_done_s)
   );

   alien_grid_divider #(.LIMIT(NUM_ROWS), .PITCH(ALIEN_SPACING_Y)) u_div_y (
      .clk       (clk),
      .rst       (rst),
      .start     (start_y_s),
      .dividend  (dy_r),
      .quotient  (row_s),
      .remainder (rem_y_s),
      .done      (y_done_s)
   );

   // Hit qualification; alive bit is only looked up for an in-range cell.
   always_comb begin
      hit_valid_s = 1'b0;
      idx_s       = '0;
      if (!miss_r && (col_s < NC_Q) && (row_s < NR_Q) &&
          (rem_x_s < W_C) && (rem_y_s < H_C)) begin
         idx_s       = IDX_W'(grid_index(row_s, col_s, NC_Q));
         hit_valid_s = alive_matrix[idx_s];
      end else begin
         hit_valid_s = 1'b0;
      end
   end

   // Next-state logic including the pending frame-boundary flag.
   always_comb begin
      state_s   = state_r;
      pending_s = pending_r;
      case (state_r)
         ARMED: begin
            if (overlap_s) begin
               state_s   = DIV_X;
               pending_s = frame_start;
            end else begin
               state_s   = ARMED;
               pending_s = 1'b0;
            end
         end
         DIV_X: begin
            pending_s = pend_any_s;
            if (x_done_s) begin
               state_s = DIV_Y;
            end else begin
               state_s = DIV_X;
            end
         end
         DIV_Y: begin
            pending_s = pend_any_s;
            if (y_done_s) begin
               state_s = CHECK;
            end else begin
               state_s = DIV_Y;
            end
         end
         CHECK: begin
            if (hit_valid_s) begin
               state_s   = KILL;
               pending_s = pend_any_s;
            end else if (pend_any_s) begin
               // A frame already ended during resolution: re-arm at once.
               state_s   = ARMED;
               pending_s = 1'b0;
            end else begin
               state_s   = WAIT_FRAME;
               pending_s = 1'b0;
            end
         end
         KILL: begin
            if (kill_valid_r && kill_ready) begin
               pending_s = 1'b0;
               if (pend_any_s) begin
                  state_s = ARMED;
               end else begin
                  state_s = WAIT_FRAME;
               end
            end else begin
               state_s   = KILL;
               pending_s = pend_any_s;
            end
         end
         WAIT_FRAME: begin
            pending_s = 1'b0;
            if (frame_start) begin
               state_s = ARMED;
            end else begin
               state_s = WAIT_FRAME;
            end
         end
         default: begin
            state_s   = ARMED;
            pending_s = 1'b0;
         end
      endcase
   end

   // State, pending flag and per-hit context registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ARMED;
         pending_r <= 1'b0;
         miss_r    <= 1'b0;
         dy_r      <= 16'd0;
      end else begin
         state_r   <= state_s;
         pending_r <= pending_s;
         if (start_x_s) begin
            miss_r <= miss_s;
            dy_r   <= dy_s;
         end
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         kill_valid_r <= 1'b0;
         kill_row_r   <= 8'd0;
         kill_col_r   <= 8'd0;
         bullet_hit_r <= 1'b0;
         hit_count_r  <= 16'd0;
         busy_r       <= 1'b0;
      end else begin
         kill_valid_r <= (state_s == KILL);
         bullet_hit_r <= (state_r == CHECK) && hit_valid_s;
         busy_r       <= !((state_s == ARMED) || (state_s == WAIT_FRAME));
         if ((state_r == CHECK) && hit_valid_s) begin
            kill_row_r <= row_s;
            kill_col_r <= col_s;
         end
         if (kill_valid_r && kill_ready && (hit_count_r != 16'hFFFF)) begin
            hit_count_r <= hit_count_r + 16'd1;
         end
      end
   end

   assign kill_valid = kill_valid_r;
   assign kill_row   = kill_row_r;
   assign kill_col   = kill_col_r;
   assign bullet_hit = bullet_hit_r;
   assign hit_count  = hit_count_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_alien_hit_resolver.sv
// ---------------------------------------------------------------------------
// tb_alien_hit_resolver
// Scoreboard bench: stimulus pushes the expected kill (row, col) computed by
// a divide/modulo reference model; a negedge monitor pops and compares when
// the DUT raises kill_valid, and tracks handshakes and the hit counter.
// ---------------------------------------------------------------------------
module tb_alien_hit_resolver;

   localparam int NR = 2;
   localparam int NC = 4;
   localparam int SX = 64;
   localparam int SY = 32;
   localparam int AW = 32;
   localparam int AH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] scan_x, scan_y, formation_x, formation_y;
   logic        frame_start, alien_pixel, bullet_pixel;
   logic [7:0]  alive_matrix;
   logic        kill_valid, kill_ready, bullet_hit, busy;
   logic [7:0]  kill_row, kill_col;
   logic [15:0] hit_count;

   alien_hit_resolver dut (
      .clk          (clk),
      .rst          (rst),
      .scan_x       (scan_x),
      .scan_y       (scan_y),
      .frame_start  (frame_start),
      .alien_pixel  (alien_pixel),
      .bullet_pixel (bullet_pixel),
      .formation_x  (formation_x),
      .formation_y  (formation_y),
      .alive_matrix (alive_matrix),
      .kill_valid   (kill_valid),
      .kill_ready   (kill_ready),
      .kill_row     (kill_row),
      .kill_col     (kill_col),
      .bullet_hit   (bullet_hit),
      .hit_count    (hit_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct { int row; int col; } kill_t;
   kill_t exp_q[$];

   int checks = 0;
   int passed = 0;
   int model_hits = 0;
   int model_kills = 0;
   int bh_seen = 0;
   bit model_armed = 1'b1;
   int cyc = 0;
   int ov_cycle = 0;
   bit ready_rand = 1'b0;
   bit ready_val = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Reference: integer divide/modulo of the offset onto the grid.
   function automatic bit ref_hit(input int x, input int y, input int fx, input int fy,
                                  input logic [7:0] alive, output int row, output int col);
      int dx, dy;
      row = 0;
      col = 0;
      if (x < fx || y < fy) return 1'b0;
      dx  = x - fx;
      dy  = y - fy;
      col = dx / SX;
      row = dy / SY;
      if (col >= NC || row >= NR) return 1'b0;
      if ((dx % SX) >= AW || (dy % SY) >= AH) return 1'b0;
      return alive[row*NC + col];
   endfunction

   // Monitor: pop on kill_valid rise, check stability, handshake, counter.
   kill_t cur;
   bit prev_kv = 1'b0;
   bit hs_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_kv = 1'b0;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            check("kill_valid_drop", kill_valid, 0);
            check("hit_count", hit_count, model_hits);
         end
         hs_prev = 1'b0;
         if (kill_valid && !prev_kv) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_kill: got row %0d col %0d, expected no kill", kill_row, kill_col);
               cur.row = -1;
               cur.col = -1;
            end else begin
               cur = exp_q.pop_front();
               check("kill_row", kill_row, cur.row);
               check("kill_col", kill_col, cur.col);
               check("bullet_hit_on_kill", bullet_hit, 1);
               check("kill_latency_ok", ((cyc - ov_cycle) <= NC + NR + 4) ? 1 : 0, 1);
            end
         end else if (kill_valid) begin
            check("kill_row_stable", kill_row, cur.row);
            check("kill_col_stable", kill_col, cur.col);
         end
         if (bullet_hit) bh_seen++;
         if (kill_valid && kill_ready) begin
            if (model_hits < 65535) model_hits++;
            hs_prev = 1'b1;
         end
         prev_kv = kill_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (ready_rand) kill_ready = 1'($urandom_range(0, 1));
      else kill_ready = ready_val;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      model_armed = 1'b1;
   endtask

   task automatic overlap(input int x, input int y);
      int r, c;
      kill_t e;
      scan_x = 16'(x);
      scan_y = 16'(y);
      alien_pixel  = 1'b1;
      bullet_pixel = 1'b1;
      if (model_armed) begin
         if (ref_hit(x, y, int'(formation_x), int'(formation_y), alive_matrix, r, c)) begin
            e.row = r;
            e.col = c;
            exp_q.push_back(e);
            model_kills++;
         end
         model_armed = 1'b0;
         ov_cycle = cyc;
      end
      tick();
      alien_pixel  = 1'b0;
      bullet_pixel = 1'b0;
   endtask

   task automatic settle();
      int n = 0;
      repeat (12) tick();
      while ((busy || kill_valid) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL settle_timeout: got busy after %0d cycles, expected idle", n);
      end
      check("expected_kills_seen", exp_q.size(), 0);
      check("bullet_hit_pulses", bh_seen, model_kills);
      exp_q.delete();
   endtask

   task automatic wait_kill();
      int n = 0;
      while (!kill_valid && n < 20) begin
         tick();
         n++;
      end
      check("kill_valid_rise_in_time", (n < 20) ? 1 : 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      int x, y;
      rst = 1'b1;
      scan_x = 16'd0; scan_y = 16'd0; frame_start = 1'b0;
      alien_pixel = 1'b0; bullet_pixel = 1'b0; kill_ready = 1'b1;
      formation_x = 16'd100; formation_y = 16'd50; alive_matrix = 8'hFF;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_kill_valid", kill_valid, 0);
      check("rst_kill_row", kill_row, 0);
      check("rst_kill_col", kill_col, 0);
      check("rst_bullet_hit", bullet_hit, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_busy", busy, 0);

      // Basic hit at (170,85): row 1, col 1.
      frame();
      overlap(170, 85);
      settle();

      // Same hit with kill_ready held low for 5 cycles.
      frame();
      ready_val = 1'b0;
      overlap(170, 85);
      wait_kill();
      repeat (5) tick();
      ready_val = 1'b1;
      settle();

      // Second overlap in the same frame is ignored; after a frame it hits (0,0).
      overlap(100, 50);
      settle();
      frame();
      overlap(100, 50);
      settle();

      // Gap between sprites, then WAIT_FRAME ignores an overlap; left of origin.
      frame();
      overlap(150, 50);
      settle();
      check("gap_busy", busy, 0);
      overlap(100, 50);
      settle();
      frame();
      overlap(90, 50);
      settle();

      // Dead alien at bit 5.
      frame();
      alive_matrix = 8'hDF;
      overlap(170, 85);
      settle();
      alive_matrix = 8'hFF;

      // Frame boundary during resolution re-arms immediately after the kill.
      frame();
      overlap(170, 85);
      frame();
      settle();
      overlap(100, 50);
      settle();

      // Reset in the middle of a kill handshake.
      frame();
      ready_val = 1'b0;
      overlap(170, 85);
      wait_kill();
      tick();
      rst = 1'b1;
      model_hits = 0;
      exp_q.delete();
      tick();
      rst = 1'b0;
      ready_val = 1'b1;
      model_armed = 1'b1;
      @(negedge clk);
      check("midkill_rst_kill_valid", kill_valid, 0);
      check("midkill_rst_busy", busy, 0);
      check("midkill_rst_hit_count", hit_count, 0);
      tick();
      overlap(100, 50);
      settle();

      // Randomized frames, formations, alive patterns and overlap positions.
      ready_rand = 1'b1;
      for (int i = 0; i < 60; i++) begin
         formation_x  = 16'($urandom_range(0, 200));
         formation_y  = 16'($urandom_range(0, 100));
         alive_matrix = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) != 0) frame();
         repeat ($urandom_range(0, 3)) begin
            scan_x = 16'($urandom_range(0, 600));
            alien_pixel  = 1'($urandom_range(0, 1));
            bullet_pixel = ~alien_pixel;
            tick();
         end
         alien_pixel = 1'b0;
         bullet_pixel = 1'b0;
         x = int'(formation_x) + $urandom_range(0, 300) - 20;
         y = int'(formation_y) + $urandom_range(0, 80) - 20;
         if (x < 0) x = 0;
         if (y < 0) y = 0;
         overlap(x, y);
         settle();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
